// File: rtl/adder_acc_sat.sv
// Handshaked signed accumulator: sums NUM operands into one WIDTH-bit result,
// saturating (SAT=1) or wrapping (SAT=0), with an exact-overflow flag.
module adder_acc_sat #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf,
  output logic [1:0]       dbg_state
);

  // Operand side: a transfer happens on a rising edge where i_valid & o_ready.
  // Result side: o_valid holds with stable o_data/o_ovf until i_ready is seen.
  localparam int AW = WIDTH + $clog2(NUM) + 1;
  localparam int CW = (NUM == 2) ? 1 : $clog2(NUM);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic signed [AW-1:0]   acc;
  logic        [CW-1:0]   cnt;

  logic                   accept;
  logic                   last;
  logic signed [AW-1:0]   data_ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   max_ext;
  logic signed [AW-1:0]   min_ext;
  logic                   ovf_next;
  logic        [WIDTH-1:0] res_next;

  assign o_ready   = (state != DONE);
  assign dbg_state = state;
  assign accept    = i_valid & o_ready;
  assign last      = (state == ACC) && (cnt == LAST_CNT);

  // The wide accumulator holds the exact sum, so range checks are plain compares.
  always_comb begin
    data_ext = {{(AW-WIDTH){i_data[WIDTH-1]}}, i_data};
    sum      = acc + data_ext;
    max_ext  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    min_ext  = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    ovf_next = (sum > max_ext) || (sum < min_ext);
    res_next = sum[WIDTH-1:0];
    if (SAT != 0) begin
      if (sum > max_ext)      res_next = max_ext[WIDTH-1:0];
      else if (sum < min_ext) res_next = min_ext[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else if (i_clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= data_ext;
            cnt   <= CW'(1);
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            if (last) begin
              o_data  <= res_next;
              o_ovf   <= ovf_next;
              o_valid <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          acc     <= '0;
          cnt     <= '0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_acc_sat.sv
// Bench for adder_acc_sat (WIDTH=8, NUM=4): a saturating and a wrapping instance
// share stimulus and are checked against an exact-integer sum model.
module tb_adder_acc_sat;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         i_clr;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         i_ready;

  logic         s_ready, s_valid, s_ovf;
  logic [W-1:0] s_data;
  logic [1:0]   s_state;
  logic         w_ready, w_valid, w_ovf;
  logic [W-1:0] w_data;
  logic [1:0]   w_state;

  int n_tests;
  int n_fail;
  int gap_max;
  int ops[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_wrap_q[$];
  logic         exp_ovf_q[$];

  adder_acc_sat #(.WIDTH(W), .NUM(4), .SAT(1)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_valid(i_valid), .o_ready(s_ready),
    .i_data(i_data), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data),
    .o_ovf(s_ovf), .dbg_state(s_state)
  );

  adder_acc_sat #(.WIDTH(W), .NUM(4), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_valid(i_valid), .o_ready(w_ready),
    .i_data(i_data), .o_valid(w_valid), .i_ready(i_ready), .o_data(w_data),
    .o_ovf(w_ovf), .dbg_state(w_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_s_data"},  32'(s_data),  32'd0);
    check({tag, "_s_ovf"},   32'(s_ovf),   32'd0);
    check({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    check({tag, "_w_data"},  32'(w_data),  32'd0);
  endtask

  // driver: one operand, optional idle gap first; called and returns at a negedge
  task automatic push(input logic [W-1:0] d);
    int g;
    g = $urandom_range(0, gap_max);
    repeat (g) @(negedge clk);
    check("ready_before_op", 32'(s_ready & w_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = d;
    ops.push_back(int'($signed(d)));
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = W'($urandom);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    push(W'(a)); push(W'(b)); push(W'(c)); push(W'(d));
  endtask

  // model: exact integer sum of the accepted group
  task automatic model_group();
    int s;
    s = 0;
    foreach (ops[i]) s += ops[i];
    ops.delete();
    exp_q.push_back((s > 127) ? 8'sd127 : (s < -128) ? 8'h80 : W'(s));
    exp_wrap_q.push_back(W'(s));
    exp_ovf_q.push_back((s > 127) || (s < -128));
  endtask

  // scoreboard: check the held result, stall `hold` cycles, then consume it
  task automatic take_result(input string tag, input int hold);
    logic [W-1:0] es, ew;
    logic         eo;
    model_group();
    es = exp_q.pop_front();
    ew = exp_wrap_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check({tag, "_valid"},    32'(s_valid & w_valid), 32'd1);
    check({tag, "_not_ready"}, 32'(s_ready | w_ready), 32'd0);
    check({tag, "_sat_data"}, 32'(s_data), 32'(es));
    check({tag, "_wrap_data"}, 32'(w_data), 32'(ew));
    check({tag, "_ovf"},      32'(s_ovf), 32'(eo));
    check({tag, "_wrap_ovf"}, 32'(w_ovf), 32'(eo));
    for (int k = 0; k < hold; k++) begin
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'd55;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(s_valid & w_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(s_ready | w_ready), 32'd0);
      check({tag, "_hold_data"},  32'({s_data, w_data}), 32'({es, ew}));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_drained"}, 32'(s_valid | w_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(s_ready & w_ready), 32'd1);
    check({tag, "_data_kept"}, 32'(s_data), 32'(es));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    gap_max = 0;
    rst = 1'b1; i_clr = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    push4(10, 20, -5, 7);       take_result("basic", 0);
    push4(100, 100, 0, 0);      take_result("pos_sat", 0);
    push4(-128, -128, -128, -128); take_result("neg_sat", 1);
    push4(127, 1, -1, 0);       take_result("mid_ovf", 0);
    push4(1, 1, 1, 1);          take_result("stall", 5);
    push4(1, 1, 1, 1);          take_result("after_stall", 0);

    // abort mid-group: the operand presented with clear is dropped
    push(8'd50); push(8'd50);
    i_clr = 1'b1; i_valid = 1'b1; i_data = 8'd9;
    @(negedge clk);
    i_clr = 1'b0; i_valid = 1'b0;
    ops.delete();
    check_idle_zero("clr_acc");
    push4(1, 2, 3, 4);          take_result("post_clr", 0);

    // abort a held result even with i_ready high
    push4(3, 3, 3, 3);
    i_clr = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_clr = 1'b0; i_ready = 1'b0;
    ops.delete();
    check_idle_zero("clr_done");
    @(negedge clk);
    check("clr_done_no_result", 32'(s_valid | w_valid), 32'd0);

    // asynchronous reset mid-group
    push(8'd7); push(8'd7); push(8'd7);
    #2 rst = 1'b1;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ops.delete();
    push4(5, 5, 5, 5);          take_result("post_rst", 0);

    // randomized groups with gaps and stalls
    gap_max = 2;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) push(W'($urandom_range(0, 255)));
      take_result("rand", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
